// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial a - b subtractor with valid/ready operand and result handshakes
//
// Purpose:
//   Takes an unsigned operand pair (a, b), runs one 1-bit full-subtractor cell
//   LSB first for WIDTH clocks, then presents diff = a - b (mod 2^WIDTH) and the
//   final borrow until the consumer takes them.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst_n       in   1      synchronous reset, active low
//   in_valid    in   1      operand pair on a/b is valid
//   in_ready    out  1      block can accept an operand pair (IDLE only)
//   a           in   WIDTH  minuend, unsigned
//   b           in   WIDTH  subtrahend, unsigned
//   out_valid   out  1      diff/borrow_out hold a completed result (DONE only)
//   out_ready   in   1      consumer takes the result
//   diff        out  WIDTH  a - b modulo 2^WIDTH
//   borrow_out  out  1      1 iff a < b

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_out_q;

  // Single full-subtractor cell working on the current LSBs.
  logic ai;
  logic bi;
  logic d_bit_d;
  logic bout_d;
  logic [WIDTH-1:0] a_sh_d;

  assign ai      = a_sh_q[0];
  assign bi      = b_sh_q[0];
  assign d_bit_d = ai ^ bi ^ borrow_q;
  assign bout_d  = (~ai & bi) | (~(ai ^ bi) & borrow_q);

  // The minuend register doubles as the result register: each consumed LSB
  // frees the MSB slot, which takes the new difference bit. After WIDTH
  // shifts it holds the full difference, LSB-aligned.
  assign a_sh_d = {d_bit_d, a_sh_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q     <= a;
            b_sh_q     <= b;
            borrow_q   <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end

        RUN: begin
          a_sh_q   <= a_sh_d;
          b_sh_q   <= b_sh_q >> 1;
          borrow_q <= bout_d;
          if (cnt_q == LAST_BIT) begin
            // Visible outputs only change here, so they stay frozen through
            // DONE and the following IDLE.
            diff_q       <= a_sh_d;
            borrow_out_q <= bout_d;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - scoreboard bench for serial_sub_ctrl at WIDTH=8 and WIDTH=13

module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, borrow8;
  logic [7:0]  a8, b8, diff8;
  logic        in_valid13, in_ready13, out_valid13, out_ready13, borrow13;
  logic [12:0] a13, b13, diff13;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .borrow_out(borrow8)
  );

  serial_sub_ctrl #(.WIDTH(13)) dut13 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid13), .in_ready(in_ready13), .a(a13), .b(b13),
    .out_valid(out_valid13), .out_ready(out_ready13),
    .diff(diff13), .borrow_out(borrow13)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int acc8    = 0;
  int acc13   = 0;

  // Expected {borrow, diff}: the reference is plain (WIDTH+1)-bit subtraction,
  // whose top bit is set exactly when a < b.
  logic [8:0]  exp8[$];
  logic [13:0] exp13[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: pushes on accepted operands, pops on consumed results.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (in_valid8 && in_ready8) begin
        exp8.push_back({1'b0, a8} - {1'b0, b8});
        acc8++;
      end
      if (out_valid8 && out_ready8) begin
        if (exp8.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL res8_unexpected: got %0h expected none", {borrow8, diff8});
        end else begin
          check("res8", {23'd0, borrow8, diff8}, {23'd0, exp8.pop_front()});
        end
      end
      check("excl8", {31'd0, in_ready8 & out_valid8}, 32'd0);

      if (in_valid13 && in_ready13) begin
        exp13.push_back({1'b0, a13} - {1'b0, b13});
        acc13++;
      end
      if (out_valid13 && out_ready13) begin
        if (exp13.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL res13_unexpected: got %0h expected none", {borrow13, diff13});
        end else begin
          check("res13", {18'd0, borrow13, diff13}, {18'd0, exp13.pop_front()});
        end
      end
      check("excl13", {31'd0, in_ready13 & out_valid13}, 32'd0);
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    a8 = a; b8 = b; in_valid8 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready8) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL send8_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic wait_out8(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid8) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL wait_out8_timeout: got out_valid=0 expected 1");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp8.size() == 0 && exp13.size() == 0) break;
    end
    check("drain", exp8.size() + exp13.size(), 32'd0);
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_in_ready8"},  {31'd0, in_ready8},  32'd1);
    check({tag, "_out_valid8"}, {31'd0, out_valid8}, 32'd0);
    check({tag, "_diff8"},      {24'd0, diff8},      32'd0);
    check({tag, "_borrow8"},    {31'd0, borrow8},    32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    bit ok;
    logic [8:0] saved;
    int target8, target13, guard;

    rst_n = 1'b0;
    in_valid8 = 0; a8 = 0; b8 = 0; out_ready8 = 0;
    in_valid13 = 0; a13 = 0; b13 = 0; out_ready13 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset state of both instances.
    @(negedge clk);
    check_idle_state("rst");
    check("rst_in_ready13",  {31'd0, in_ready13},  32'd1);
    check("rst_out_valid13", {31'd0, out_valid13}, 32'd0);
    check("rst_diff13",      {19'd0, diff13},      32'd0);
    check("rst_borrow13",    {31'd0, borrow13},    32'd0);

    // 9 - 5: latency from acceptance edge and single-cycle out_valid.
    @(posedge clk); #1;
    out_ready8 = 1'b1;
    a8 = 8'd9; b8 = 8'd5; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (out_valid8) break;
    end
    check("lat_9m5", k, 32'd8);
    check("diff_9m5", {23'd0, borrow8, diff8}, 32'h004);
    @(negedge clk);
    check("pulse_9m5", {31'd0, out_valid8}, 32'd0);

    // Borrow cases and equal operands.
    send8(8'd5, 8'd9);
    wait_out8(ok);
    check("diff_5m9", {23'd0, borrow8, diff8}, 32'h1FC);
    send8(8'h00, 8'hFF);
    wait_out8(ok);
    check("diff_0mFF", {23'd0, borrow8, diff8}, 32'h101);
    send8(8'hA5, 8'hA5);
    wait_out8(ok);
    check("diff_eq", {23'd0, borrow8, diff8}, 32'h000);
    drain();

    // Backpressure with fresh operands pending on the input.
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    send8(8'h30, 8'h31);
    wait_out8(ok);
    saved = {borrow8, diff8};
    check("bp_result", {23'd0, saved}, 32'h1FF);
    @(posedge clk); #1;
    a8 = 8'h77; b8 = 8'h11; in_valid8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid8}, 32'd1);
      check("bp_in_ready",  {31'd0, in_ready8},  32'd0);
      check("bp_hold",      {23'd0, borrow8, diff8}, {23'd0, saved});
    end
    @(posedge clk); #1;
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_after_in_ready",  {31'd0, in_ready8},  32'd1);
    check("bp_after_out_valid", {31'd0, out_valid8}, 32'd0);
    check("bp_keep_last",       {23'd0, borrow8, diff8}, {23'd0, saved});
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    drain();

    // Reset in the third RUN cycle drops the operation.
    send8(8'hC3, 8'h5A);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp8.delete();
    @(negedge clk);
    check_idle_state("midrst");
    send8(8'h12, 8'h34);
    wait_out8(ok);
    check("post_rst", {23'd0, borrow8, diff8}, 32'h1DE);
    drain();

    // Random sweep on both widths with random in_valid and out_ready.
    target8  = acc8 + 1000;
    target13 = acc13 + 1000;
    fork
      begin
        guard = 0;
        while (acc8 < target8 && guard < 60000) begin
          @(posedge clk); #1;
          guard++;
          in_valid8  = ($urandom_range(0, 3) != 0);
          a8 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
          b8 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
          out_ready8 = ($urandom_range(0, 1) != 0);
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
      end
      begin
        int g13;
        g13 = 0;
        while (acc13 < target13 && g13 < 60000) begin
          @(posedge clk); #1;
          g13++;
          in_valid13  = ($urandom_range(0, 3) != 0);
          a13 = ($urandom_range(0, 7) == 0) ? 13'h1FFF : 13'($urandom);
          b13 = ($urandom_range(0, 7) == 0) ? 13'h0000 : 13'($urandom);
          out_ready13 = ($urandom_range(0, 1) != 0);
        end
        in_valid13 = 1'b0; out_ready13 = 1'b1;
      end
    join
    drain();
    check("sweep_count8",  acc8  >= target8,  32'd1);
    check("sweep_count13", acc13 >= target13, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
